rams_sp_bwe_pipe: RTL and testbench
===================================

RAMS_SP_BWE_PIPE -- requirements
Module: rams_sp_bwe_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits, an integer multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, address width.
REQ-004 SHALL have parameter DATA_DEPTH, default 1024, number of words, at most 2**ADDR_WIDTH.
REQ-005 SHALL have parameter OUT_REG, default 1: 0 gives read latency 1, 1 gives read latency 2.
REQ-006 SHALL have parameter WRITE_MODE, default 0: 0 is read-first, 1 is write-first.
REQ-007 SHALL have port clk  in  1  clock, all state on the rising edge.
REQ-008 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port req_valid  in  1  request present.
REQ-010 SHALL have port req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-011 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-012 SHALL have port req_be  in  NB  per-lane write enable.
REQ-013 SHALL have port req_addr  in  ADDR_WIDTH  word address.
REQ-014 SHALL have port req_wdata  in  DATA_WIDTH  write data.
REQ-015 SHALL have port rsp_valid  out  1  read response present.
REQ-016 SHALL have port rsp_ready  in  1  consumer accepts the response.
REQ-017 SHALL have port rsp_rdata  out  DATA_WIDTH  read data.
REQ-018 SHALL have port rsp_err  out  1  response belongs to an out-of-range address.

Function
REQ-019 SHALL hold DATA_DEPTH words, all initialised to zero at configuration, implemented as block RAM.
REQ-020 SHALL accept a request (fire) when req_valid and req_ready are both high.
REQ-021 On a write fire with req_addr < DATA_DEPTH, SHALL update lane i only where req_be[i]=1.
REQ-022 A write fire SHALL produce no response.
REQ-023 On a read fire, SHALL present exactly one response, in order, after exactly OUT_REG+1 cycles when not stalled.
REQ-024 A read with req_addr >= DATA_DEPTH SHALL respond with rsp_rdata=0 and rsp_err=1; a write to such an address SHALL be dropped silently.
REQ-025 In write-first mode, a read fire SHALL always see data from earlier write fires; a read issued the cycle after a write to the same address SHALL return the new data.
REQ-026 In read-first mode, the same ordering rule as REQ-025 SHALL apply, because only one request fires per cycle.
REQ-027 Pipeline stages SHALL be S1 (RAM output) and, when OUT_REG=1, S2 (output register); each stage SHALL carry valid, data and err.
REQ-028 The last stage SHALL drive rsp_* and SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-029 A stage SHALL advance when the stage after it is empty or is being drained that cycle; otherwise it SHALL hold, with the RAM enable deasserted.
REQ-030 When OUT_REG=0, req_ready SHALL be !S1.valid || rsp_ready.
REQ-031 When OUT_REG=1, req_ready SHALL be !S1.valid || !S2.valid || rsp_ready.
REQ-032 At full throughput (rsp_ready held high), SHALL sustain one request per cycle with no bubbles.
REQ-033 When a response drains and a new read fires in the same cycle, SHALL keep both without loss or duplication.
REQ-034 A request presented while req_ready=0 SHALL have no effect, including no write.

Reset
REQ-035 While rst_n=0, SHALL clear all stage valid bits, rsp_valid, rsp_err and rsp_rdata to 0, and SHALL force req_ready to 0.
REQ-036 Reset SHALL NOT alter RAM contents.
REQ-037 Reset asserted mid-operation SHALL discard in-flight reads; no response for them SHALL appear after release.
REQ-038 On the first rising edge after rst_n releases, SHALL set req_ready to 1.

Verification
REQ-039 Byte-enable write: write 0xAABBCCDD to addr 5 with be=1111, then write 0x11223344 to addr 5 with be=0101, then read addr 5 -> rsp_rdata=0xAA22CC44, err=0, returned OUT_REG+1 cycles after the read fire.
REQ-040 Back-to-back reads: write addr 0..7 with value 100+n, then read addr 0..7 in 8 consecutive cycles with rsp_ready=1 -> 8 responses in consecutive cycles, values 100..107 in order.
REQ-041 Backpressure: as REQ-040, with rsp_ready=0 for cycles 3-6 -> rsp_* frozen while stalled, req_ready=0 once the pipeline is full, no lost or duplicated responses, and order preserved.
REQ-042 Out of range: with DATA_DEPTH=1000, write then read addr 1000 -> rsp_rdata=0, rsp_err=1, and addr 0 unchanged.
REQ-043 Write-then-read: write 0xDEADBEEF to addr 3, then read addr 3 the next cycle, in both WRITE_MODE values -> 0xDEADBEEF.
REQ-044 Reset mid-flight: issue 2 reads, assert rst_n=0 one cycle later -> rsp_valid=0 immediately, no response after release, and a subsequent read of the same address returns its pre-reset contents.

Source files
------------

// File: rtl/rams_sp_bwe_pipe_if.sv
// Request/response bus of the pipelined single-port byte-write RAM.
// The requester uses the master modport and the RAM uses the slave modport.
interface rams_sp_bwe_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NB-1:0]         req_be;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rams_sp_bwe_pipe.sv
// Single-port block RAM with per-byte write enables and a valid/ready read pipeline:
// S1 is the RAM output register, and S2 is an optional output register.
module rams_sp_bwe_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int OUT_REG    = 1,
  parameter int WRITE_MODE = 0
) (
  input logic                clk,
  input logic                rst_n,
  rams_sp_bwe_pipe_if.slave  bus
);
  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = DATA_DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic                  r_ready_en;
  logic                  r_s1_valid;
  logic                  r_s1_err;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [NB-1:0]         w_be;
  logic                  w_we;
  logic                  w_in_range;
  logic                  w_s1_adv;
  logic                  w_s1_load;
  logic                  w_fire;
  logic                  w_rd_fire;
  logic                  w_ram_en;
  logic [DATA_WIDTH-1:0] w_s1_data;

  assign w_addr     = bus.req_addr;
  assign w_wdata    = bus.req_wdata;
  assign w_be       = bus.req_be;
  assign w_we       = bus.req_we;
  assign w_in_range = {1'b0, w_addr} < LP_DEPTH;

  // S1 can take a new entry only when it is empty or hands its entry on this cycle.
  assign w_s1_load     = !r_s1_valid || w_s1_adv;
  assign bus.req_ready = r_ready_en && w_s1_load;
  assign w_fire        = bus.req_valid && bus.req_ready;
  assign w_rd_fire     = w_fire && !w_we;
  assign w_ram_en      = w_fire && w_in_range;

  // Every fire also reloads S1, so the RAM output register can be overwritten on writes.
  generate
    if (WRITE_MODE != 0) begin : g_write_first
      always_ff @(posedge clk) begin
        if (w_ram_en) begin
          for (int i = 0; i < NB; i++) begin
            if (w_we && w_be[i]) begin
              r_mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
              r_ram_q[i*BYTE_WIDTH +: BYTE_WIDTH]       <= w_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end else begin
              r_ram_q[i*BYTE_WIDTH +: BYTE_WIDTH] <= r_mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end else begin : g_read_first
      always_ff @(posedge clk) begin
        if (w_ram_en) begin
          for (int i = 0; i < NB; i++) begin
            if (w_we && w_be[i]) begin
              r_mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
          r_ram_q <= r_mem[w_addr];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_s1_load) begin
        r_s1_valid <= w_rd_fire;
        r_s1_err   <= w_rd_fire && !w_in_range;
      end
    end
  end

  // Out-of-range reads never load the RAM register, so their data is forced to zero here.
  assign w_s1_data = (r_s1_valid && !r_s1_err) ? r_ram_q : '0;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s2_valid;
      logic                  r_s2_err;
      logic [DATA_WIDTH-1:0] r_s2_data;

      assign w_s1_adv = !r_s2_valid || bus.rsp_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s2_valid <= 1'b0;
          r_s2_err   <= 1'b0;
          r_s2_data  <= '0;
        end else if (w_s1_adv) begin
          r_s2_valid <= r_s1_valid;
          r_s2_err   <= r_s1_err;
          r_s2_data  <= w_s1_data;
        end
      end

      assign bus.rsp_valid = r_s2_valid;
      assign bus.rsp_err   = r_s2_err;
      assign bus.rsp_rdata = r_s2_data;
    end else begin : g_no_out_reg
      assign w_s1_adv      = bus.rsp_ready;
      assign bus.rsp_valid = r_s1_valid;
      assign bus.rsp_err   = r_s1_err;
      assign bus.rsp_rdata = w_s1_data;
    end
  endgenerate
endmodule

// File: tb/tb_rams_sp_bwe_pipe.sv
// Directed bench for rams_sp_bwe_pipe: dut_a (depth 1000, OUT_REG=1, read-first)
// and dut_b (depth 1024, OUT_REG=0, write-first) share stimulus selected by sel.
module tb_rams_sp_bwe_pipe;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 10;
  localparam int NB = DW / BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sel;
  int            lat;
  logic          req_valid;
  logic          req_we;
  logic [NB-1:0] req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_ready;
  int            passes = 0;
  int            total  = 0;

  always #5 clk = ~clk;

  rams_sp_bwe_pipe_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) if_a ();
  rams_sp_bwe_pipe_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) if_b ();

  assign if_a.req_valid = req_valid && !sel;
  assign if_a.req_we    = req_we;
  assign if_a.req_be    = req_be;
  assign if_a.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_a.rsp_ready = rsp_ready;
  assign if_b.req_valid = req_valid && sel;
  assign if_b.req_we    = req_we;
  assign if_b.req_be    = req_be;
  assign if_b.req_addr  = req_addr;
  assign if_b.req_wdata = req_wdata;
  assign if_b.rsp_ready = rsp_ready;

  rams_sp_bwe_pipe #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
    .DATA_DEPTH(1000), .OUT_REG(1), .WRITE_MODE(0)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));

  rams_sp_bwe_pipe #(
    .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
    .DATA_DEPTH(1024), .OUT_REG(0), .WRITE_MODE(1)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  logic          obs_ready;
  logic          obs_valid;
  logic          obs_err;
  logic [DW-1:0] obs_rdata;
  assign obs_ready = sel ? if_b.req_ready : if_a.req_ready;
  assign obs_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign obs_err   = sel ? if_b.rsp_err   : if_a.rsp_err;
  assign obs_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (obs_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, {31'b0, obs_ready}, 32'd1);
  endtask

  task automatic do_write(input int addr, input logic [DW-1:0] data, input logic [NB-1:0] be,
                          input string tag);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = AW'(addr);
    req_wdata = data;
    req_be    = be;
    #1;
    wait_ready(tag);
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic do_read(input int addr, input logic [DW-1:0] exp_data, input logic exp_err,
                         input string tag);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'(addr);
    #1;
    wait_ready(tag);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check({tag, "_early_valid"}, {31'b0, obs_valid}, 32'd0);
      tick();
    end
    check({tag, "_valid"}, {31'b0, obs_valid}, 32'd1);
    check({tag, "_rdata"}, obs_rdata, exp_data);
    check({tag, "_err"}, {31'b0, obs_err}, {31'b0, exp_err});
    tick();
    check({tag, "_no_dup"}, {31'b0, obs_valid}, 32'd0);
  endtask

  task automatic back_to_back(input string tag);
    logic exp_v;
    for (int n = 0; n < 8; n++) do_write(n, DW'(100 + n), 4'hF, {tag, "_wr"});
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 8 + lat + 1; cyc++) begin
      req_valid = (cyc < 8);
      req_we    = 1'b0;
      req_addr  = AW'(cyc % 8);
      #1;
      if (cyc < 8) check({tag, "_ready"}, {31'b0, obs_ready}, 32'd1);
      exp_v = (cyc >= lat) && (cyc < 8 + lat);
      check({tag, "_valid"}, {31'b0, obs_valid}, {31'b0, exp_v});
      if (exp_v) check({tag, "_rdata"}, obs_rdata, DW'(100 + cyc - lat));
      tick();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int iss;
    int got;
    rst_n     = 1'b0;
    sel       = 1'b0;
    lat       = 2;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    tick();
    tick();

    // Reset state of both instances.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check("rst_valid", {31'b0, obs_valid}, 32'd0);
      check("rst_ready", {31'b0, obs_ready}, 32'd0);
      check("rst_err",   {31'b0, obs_err},   32'd0);
      check("rst_rdata", obs_rdata, 32'd0);
    end
    sel   = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_ready_before_edge", {31'b0, obs_ready}, 32'd0);
    tick();
    check("rel_ready_after_edge", {31'b0, obs_ready}, 32'd1);

    // dut_a: byte enables, out of range, streaming, backpressure, write-then-read.
    do_write(5, 32'hAABBCCDD, 4'b1111, "a_be_wr1");
    do_write(5, 32'h11223344, 4'b0101, "a_be_wr2");
    do_read(5, 32'hAA22CC44, 1'b0, "a_be_rd");

    do_write(0, 32'h12345678, 4'hF, "a_oor_wr0");
    do_write(1000, 32'hFFFFFFFF, 4'hF, "a_oor_wr");
    do_read(1000, 32'h0, 1'b1, "a_oor_rd");
    do_read(0, 32'h12345678, 1'b0, "a_oor_addr0");

    back_to_back("a_b2b");

    // Stall cycles 3..6: S1/S2 fill, req_ready drops, response 101 is held.
    iss = 0;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      rsp_ready = !(cyc >= 3 && cyc <= 6);
      req_valid = (iss < 8);
      req_we    = 1'b0;
      req_addr  = AW'(iss % 8);
      #1;
      if (cyc >= 3 && cyc <= 6) begin
        check("a_bp_ready_low", {31'b0, obs_ready}, 32'd0);
        check("a_bp_hold_valid", {31'b0, obs_valid}, 32'd1);
        check("a_bp_hold_rdata", obs_rdata, 32'd101);
        check("a_bp_hold_err", {31'b0, obs_err}, 32'd0);
      end
      if (obs_valid && rsp_ready) begin
        check("a_bp_order", obs_rdata, DW'(100 + got));
        got++;
      end
      if (req_valid && obs_ready) iss++;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    check("a_bp_count", DW'(got), 32'd8);
    #1;
    tick();
    check("a_bp_no_extra", {31'b0, obs_valid}, 32'd0);

    do_write(3, 32'hDEADBEEF, 4'hF, "a_wtr_wr");
    do_read(3, 32'hDEADBEEF, 1'b0, "a_wtr_rd");

    // dut_b: latency 1, write-first.
    sel = 1'b1;
    lat = 1;
    do_write(5, 32'hAABBCCDD, 4'b1111, "b_be_wr1");
    do_write(5, 32'h11223344, 4'b0101, "b_be_wr2");
    do_read(5, 32'hAA22CC44, 1'b0, "b_be_rd");
    do_write(3, 32'hDEADBEEF, 4'hF, "b_wtr_wr");
    do_read(3, 32'hDEADBEEF, 1'b0, "b_wtr_rd");
    back_to_back("b_b2b");

    // dut_a: reset with two reads in flight.
    sel = 1'b0;
    lat = 2;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'(2);
    tick();
    req_addr  = AW'(3);
    tick();
    req_valid = 1'b0;
    #1;
    check("a_mid_pre_valid", {31'b0, obs_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("a_mid_rst_valid", {31'b0, obs_valid}, 32'd0);
    check("a_mid_rst_ready", {31'b0, obs_ready}, 32'd0);
    check("a_mid_rst_rdata", obs_rdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("a_mid_rel_ready0", {31'b0, obs_ready}, 32'd0);
    tick();
    check("a_mid_rel_ready1", {31'b0, obs_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("a_mid_no_rsp", {31'b0, obs_valid}, 32'd0);
      tick();
    end
    do_read(2, 32'd102, 1'b0, "a_mid_reread");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
